// File: rtl/uart_pkg.sv
// Shared types and defaults for the oversampling UART receiver.
package uart_pkg;

  localparam int CLK_HZ         = 50_000_000;
  localparam int BAUD           = 9600;
  localparam int DEF_DATA_BITS  = 8;
  localparam int DEF_OVERSAMPLE = 16;

  // Receiver frame states; BREAK parks the FSM while the line is held low.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_sync_ff.sv
// Multi-flop synchroniser for an asynchronous, idle-high input.
module uart_sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the raw input through the chain; reset to 1 so an idle line never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '1;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/uart_rx_os16.sv
// 8N1 UART receiver driven by a 16x oversample tick, with rdy/rdy_clr handshake
// and sticky framing / overrun flags.
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int OVERSAMPLE  = DEF_OVERSAMPLE,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_en,
  input  logic                 rx,
  input  logic                 rdy_clr,
  input  logic                 err_clr,
  output logic [DATA_BITS-1:0] data,
  output logic                 rdy,
  output logic                 busy,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int SC_W = cnt_width(OVERSAMPLE);
  localparam int BI_W = cnt_width(DATA_BITS);

  localparam logic [SC_W-1:0] HALF_LAST = SC_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SC_W-1:0] CELL_LAST = SC_W'(OVERSAMPLE - 1);
  localparam logic [BI_W-1:0] LAST_BIT  = BI_W'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state;
  logic [SC_W-1:0]      sample_cnt;
  logic [BI_W-1:0]      bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 stop_sample;
  logic                 byte_done;
  logic                 frame_bad;

  uart_sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (rx),
    .q    (rx_s)
  );

  assign stop_sample = rx_en && (state == STOP) && (sample_cnt == CELL_LAST);
  assign byte_done   = stop_sample && rx_s;
  assign frame_bad   = stop_sample && !rx_s;

  // Frame FSM: start detection, mid-cell data sampling, stop check and break wait, all paced by rx_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sample_cnt <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      busy       <= 1'b0;
    end else if (rx_en) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state      <= START;
            sample_cnt <= '0;
            busy       <= 1'b1;
          end
        end
        START: begin
          if (sample_cnt == HALF_LAST) begin
            sample_cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            sample_cnt <= sample_cnt + SC_W'(1);
          end
        end
        DATA: begin
          if (sample_cnt == CELL_LAST) begin
            sample_cnt <= '0;
            shreg      <= {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + BI_W'(1);
            end
          end else begin
            sample_cnt <= sample_cnt + SC_W'(1);
          end
        end
        STOP: begin
          if (sample_cnt == CELL_LAST) begin
            sample_cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= BREAK;
            end
          end else begin
            sample_cnt <= sample_cnt + SC_W'(1);
          end
        end
        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          sample_cnt <= '0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  // Output handshake: a completing byte beats rdy_clr, and a newly raised error beats err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data      <= '0;
      rdy       <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (byte_done) begin
        data <= shreg;
        rdy  <= 1'b1;
      end else if (rdy_clr) begin
        rdy <= 1'b0;
      end

      if (byte_done && rdy && !rdy_clr) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end

      if (frame_bad) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Self-checking bench for uart_rx_os16: rx_en every 4 clk, so one bit cell is 64 clk.
module tb_uart_rx_os16;

  localparam int CELL = 64;

  logic       clk;
  logic       rst_n;
  logic       rx_en;
  logic       rx;
  logic       rdy_clr;
  logic       err_clr;
  logic [7:0] data;
  logic       rdy;
  logic       busy;
  logic       frame_err;
  logic       overrun;

  int         total = 0;
  int         bad   = 0;
  int         phase = 0;
  logic [7:0] expQ[$];

  uart_rx_os16 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rx_en    (rx_en),
    .rx       (rx),
    .rdy_clr  (rdy_clr),
    .err_clr  (err_clr),
    .data     (data),
    .rdy      (rdy),
    .busy     (busy),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  // 50 MHz clock
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Guard against a hung run
  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance to the next negedge and set up rx_en for the following posedge
  task automatic tickClk();
    @(negedge clk);
    rx_en = (phase == 3);
    phase = (phase + 1) % 4;
  endtask

  task automatic idleClocks(input int n);
    for (int k = 0; k < n; k++) tickClk();
  endtask

  // One frame: start, 8 data bits LSB first, stop. Cell i of the frame covers posedges n0+i.
  // clrAt pulses rdy_clr at that offset; rstAt pulses rst_n low at that offset for 4 clk.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit,
                               input int clrAt, input int rstAt);
    logic [9:0] frame;
    frame = {stopBit, b, 1'b0};
    while (phase != 1) tickClk();
    if (stopBit && rstAt < 0) expQ.push_back(b);
    for (int i = 0; i < 10 * CELL; i++) begin
      tickClk();
      rx      = frame[i / CELL];
      rdy_clr = (i == clrAt);
      if (i == rstAt) begin
        rst_n = 1'b0;
        #1;
        checkOutput("rst_data", {24'd0, data}, 32'h0);
        checkOutput("rst_rdy", {31'd0, rdy}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_ferr", {31'd0, frame_err}, 32'd0);
        checkOutput("rst_ovr", {31'd0, overrun}, 32'd0);
      end
      if (rstAt >= 0 && i == rstAt + 4) rst_n = 1'b1;
    end
    rdy_clr = 1'b0;
  endtask

  // Bounded wait for rdy, then compare data against the scoreboard head
  task automatic awaitByte(input string tag);
    int n;
    logic [7:0] exp;
    n = 0;
    while (!rdy && n < 200) begin
      tickClk();
      n++;
    end
    checkOutput({tag, "_rdy"}, {31'd0, rdy}, 32'd1);
    if (expQ.size() > 0) begin
      exp = expQ.pop_front();
      checkOutput({tag, "_data"}, {24'd0, data}, {24'd0, exp});
    end
  endtask

  task automatic pulseRdyClr();
    tickClk();
    rdy_clr = 1'b1;
    tickClk();
    rdy_clr = 1'b0;
  endtask

  task automatic pulseErrClr();
    tickClk();
    err_clr = 1'b1;
    tickClk();
    err_clr = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    rx_en   = 1'b0;
    rx      = 1'b1;
    rdy_clr = 1'b0;
    err_clr = 1'b0;
    idleClocks(5);
    checkOutput("reset_data", {24'd0, data}, 32'h0);
    checkOutput("reset_rdy", {31'd0, rdy}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_ferr", {31'd0, frame_err}, 32'd0);
    checkOutput("reset_ovr", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    idleClocks(20);

    // Basic byte and rdy_clr
    applyStimulus(8'hA5, 1'b1, -1, -1);
    awaitByte("a5");
    checkOutput("a5_ferr", {31'd0, frame_err}, 32'd0);
    pulseRdyClr();
    checkOutput("a5_rdy_clr", {31'd0, rdy}, 32'd0);
    checkOutput("a5_hold", {24'd0, data}, 32'hA5);

    // Overrun
    applyStimulus(8'h3C, 1'b1, -1, -1);
    awaitByte("3c");
    checkOutput("3c_ovr", {31'd0, overrun}, 32'd0);
    applyStimulus(8'h81, 1'b1, -1, -1);
    awaitByte("81");
    checkOutput("81_ovr", {31'd0, overrun}, 32'd1);
    pulseErrClr();
    checkOutput("ovr_clr", {31'd0, overrun}, 32'd0);
    checkOutput("ovr_clr_rdy", {31'd0, rdy}, 32'd1);
    pulseRdyClr();

    // Glitch shorter than half a bit
    while (phase != 1) tickClk();
    for (int i = 0; i < 12; i++) begin
      tickClk();
      rx = 1'b0;
      if (i == 8) checkOutput("glitch_busy_hi", {31'd0, busy}, 32'd1);
    end
    tickClk();
    rx = 1'b1;
    idleClocks(60);
    checkOutput("glitch_busy_lo", {31'd0, busy}, 32'd0);
    checkOutput("glitch_rdy", {31'd0, rdy}, 32'd0);
    checkOutput("glitch_ferr", {31'd0, frame_err}, 32'd0);
    checkOutput("glitch_ovr", {31'd0, overrun}, 32'd0);

    // Framing error then held-low line
    applyStimulus(8'h55, 1'b0, -1, -1);
    idleClocks(19 * CELL);
    checkOutput("brk_ferr", {31'd0, frame_err}, 32'd1);
    checkOutput("brk_rdy", {31'd0, rdy}, 32'd0);
    checkOutput("brk_busy", {31'd0, busy}, 32'd1);
    checkOutput("brk_data", {24'd0, data}, 32'h81);
    rx = 1'b1;
    idleClocks(2 * CELL);
    checkOutput("brk_release", {31'd0, busy}, 32'd0);
    applyStimulus(8'h0F, 1'b1, -1, -1);
    awaitByte("0f");
    checkOutput("0f_ferr_sticky", {31'd0, frame_err}, 32'd1);
    pulseErrClr();
    checkOutput("ferr_clr", {31'd0, frame_err}, 32'd0);
    pulseRdyClr();

    // rdy_clr on the completion clock of a second byte (stop sampled at offset 610)
    applyStimulus(8'h12, 1'b1, -1, -1);
    awaitByte("12");
    applyStimulus(8'h34, 1'b1, 610, -1);
    awaitByte("34");
    checkOutput("34_ovr", {31'd0, overrun}, 32'd0);

    // Reset mid-DATA, then a clean frame
    applyStimulus(8'hFF, 1'b1, -1, 200);
    idleClocks(CELL);
    checkOutput("post_rst_busy", {31'd0, busy}, 32'd0);
    applyStimulus(8'hFF, 1'b1, -1, -1);
    awaitByte("ff");
    checkOutput("ff_ovr", {31'd0, overrun}, 32'd0);
    checkOutput("sb_empty", expQ.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
